// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: parses a counted, checksummed byte stream,
// writes big-endian words to consecutive addresses and holds the CPU until a clean load.
module imem_boot_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_HI  = 3'd1,
        HDR_LO  = 3'd2,
        PAYLOAD = 3'd3,
        WRITE   = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                state_r;
    logic [7:0]            cnt_hi_r;
    logic [ADDR_WIDTH:0]   n_r;
    logic [23:0]           asm_r;
    logic [1:0]            byte_cnt_r;
    logic [7:0]            xor_r;
    logic [TW-1:0]         timer_r;

    logic                  byte_s;
    logic                  counting_s;
    logic                  timeout_s;
    logic [15:0]           hdr_n_s;
    logic [ADDR_WIDTH:0]   words_next_s;

    // A session may carry between 1 and DEPTH words; anything else is rejected up front.
    function automatic logic count_ok(input logic [15:0] n);
        return (n != 16'd0) && ({1'b0, n} <= DEPTH);
    endfunction

    assign byte_s       = rx_valid & rx_ready;
    assign counting_s   = (state_r == HDR_HI) || (state_r == HDR_LO) ||
                          (state_r == PAYLOAD) || (state_r == CHECK);
    assign timeout_s    = (timer_r == TW'(TIMEOUT_CYCLES - 1));
    assign hdr_n_s      = {cnt_hi_r, rx_data};
    assign words_next_s = words_loaded + (ADDR_WIDTH + 1)'(1);

    // Loader FSM with all outputs registered; rx_ready is decided one cycle ahead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_hi_r     <= 8'd0;
            n_r          <= '0;
            asm_r        <= 24'd0;
            byte_cnt_r   <= 2'd0;
            xor_r        <= 8'd0;
            timer_r      <= '0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            if (counting_s) begin
                timer_r <= byte_s ? '0 : timer_r + TW'(1);
            end
            case (state_r)
                IDLE: begin
                    if (load_req) begin
                        state_r      <= HDR_HI;
                        rx_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        byte_cnt_r   <= 2'd0;
                        xor_r        <= 8'd0;
                        timer_r      <= '0;
                    end
                end
                HDR_HI: begin
                    if (byte_s) begin
                        cnt_hi_r <= rx_data;
                        state_r  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (byte_s) begin
                        if (count_ok(hdr_n_s)) begin
                            n_r     <= hdr_n_s[ADDR_WIDTH:0];
                            state_r <= PAYLOAD;
                        end else begin
                            state_r    <= IDLE;
                            rx_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_s) begin
                        asm_r      <= {asm_r[15:0], rx_data};
                        xor_r      <= xor_r ^ rx_data;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            state_r   <= WRITE;
                            rx_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_waddr <= words_loaded[ADDR_WIDTH-1:0];
                            mem_wdata <= {asm_r, rx_data};
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= words_next_s;
                    rx_ready     <= 1'b1;
                    state_r      <= (words_next_s == n_r) ? CHECK : PAYLOAD;
                end
                CHECK: begin
                    if (byte_s) begin
                        rx_ready <= 1'b0;
                        if (rx_data == xor_r) begin
                            state_r   <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state_r    <= IDLE;
                            load_error <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    cpu_hold <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
            // A stalled source aborts the session; this overrides any transition above.
            if (counting_s && !byte_s && timeout_s) begin
                state_r    <= IDLE;
                rx_ready   <= 1'b0;
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (ADDR_WIDTH=8, short timeout).
module tb_imem_boot_loader;

    localparam int AW = 8;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_req;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int ready_in_write = 0;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [7:0]    pl[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    logic [7:0]    good_chk;

    imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write/pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_waddr);
            wr_data.push_back(mem_wdata);
            if (rx_ready) ready_in_write++;
        end
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Offer a byte and hold it until accepted; returns on the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'hxx;
    endtask

    task automatic send_stream(input int gapmod, input logic [7:0] chk);
        send_byte(8'h00);
        send_byte(8'h02);
        for (int i = 0; i < 8; i++) begin
            if (gapmod > 0) cycles(i % gapmod);
            send_byte(pl[i]);
        end
        send_byte(chk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, 32'(wr_addr[0]), 32'h0);
            check({tag, "_d0"}, wr_data[0], 32'h20080005);
            check({tag, "_a1"}, 32'(wr_addr[1]), 32'h1);
            check({tag, "_d1"}, wr_data[1], 32'h00000008);
        end
    endtask

    initial begin
        good_chk = 8'h00;
        for (int i = 0; i < 8; i++) good_chk = good_chk ^ pl[i];
        reset = 1'b0; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cycles(2);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b1;
        cycles(2);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);

        // Happy path, with latency check on the first word.
        clear_log();
        pulse_req();
        check("hp_rx_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(pl[0]); send_byte(pl[1]); send_byte(pl[2]); send_byte(pl[3]);
        check("hp_we_latency", 32'(mem_we), 32'd1);
        check("hp_ready_in_write", 32'(rx_ready), 32'd0);
        for (int i = 4; i < 8; i++) send_byte(pl[i]);
        send_byte(good_chk);
        check("hp_done_pulse", 32'(load_done), 32'd1);
        cycles(1);
        check("hp_done_low", 32'(load_done), 32'd0);
        check("hp_cpu_hold", 32'(cpu_hold), 32'd0);
        check("hp_words", 32'(words_loaded), 32'd2);
        check("hp_error", 32'(load_error), 32'd0);
        check("hp_done_cnt", 32'(done_cnt), 32'd1);
        check_writes("hp");

        // Bad checksum; the new request must reassert cpu_hold next cycle.
        clear_log();
        pulse_req();
        check("bc_hold_reassert", 32'(cpu_hold), 32'd1);
        send_stream(0, good_chk ^ 8'h2D);
        check("bc_error", 32'(load_error), 32'd1);
        check("bc_cpu_hold", 32'(cpu_hold), 32'd1);
        check("bc_rx_ready", 32'(rx_ready), 32'd0);
        cycles(2);
        check("bc_done_cnt", 32'(done_cnt), 32'd0);
        check_writes("bc");

        // Bad counts: zero and one beyond memory depth.
        clear_log();
        pulse_req();
        check("zc_error_cleared", 32'(load_error), 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        check("zc_error", 32'(load_error), 32'd1);
        check("zc_rx_ready", 32'(rx_ready), 32'd0);
        pulse_req();
        send_byte(8'h01); send_byte(8'h01);
        check("oc_error", 32'(load_error), 32'd1);
        check("oc_rx_ready", 32'(rx_ready), 32'd0);
        cycles(3);
        check("bad_cnt_no_we", 32'(wr_addr.size()), 32'd0);
        check("bad_cnt_hold", 32'(cpu_hold), 32'd1);

        // Gaps between bytes give identical writes.
        clear_log();
        pulse_req();
        send_stream(4, good_chk);
        cycles(2);
        check("gap_done_cnt", 32'(done_cnt), 32'd1);
        check("gap_error", 32'(load_error), 32'd0);
        check("gap_cpu_hold", 32'(cpu_hold), 32'd0);
        check_writes("gap");
        check("ready_in_write", 32'(ready_in_write), 32'd0);

        // Ignored mid-session request, then timeout in PAYLOAD.
        clear_log();
        pulse_req();
        send_byte(8'h00); send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(pl[i]);
        cycles(2);
        check("to_words1", 32'(words_loaded), 32'd1);
        pulse_req();
        cycles(2);
        check("ign_words", 32'(words_loaded), 32'd1);
        check("ign_rx_ready", 32'(rx_ready), 32'd1);
        check("ign_error", 32'(load_error), 32'd0);
        cycles(TO - 60);
        check("to_not_yet", 32'(load_error), 32'd0);
        cycles(80);
        check("to_error", 32'(load_error), 32'd1);
        check("to_rx_ready", 32'(rx_ready), 32'd0);
        check("to_cpu_hold", 32'(cpu_hold), 32'd1);

        // Asynchronous reset mid-PAYLOAD.
        pulse_req();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(pl[0]); send_byte(pl[1]);
        reset = 1'b0;
        cycles(1);
        check("mr_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mr_rx_ready", 32'(rx_ready), 32'd0);
        check("mr_mem_we", 32'(mem_we), 32'd0);
        check("mr_error", 32'(load_error), 32'd0);
        check("mr_words", 32'(words_loaded), 32'd0);
        reset = 1'b1;
        cycles(2);
        check("mr_idle_ready", 32'(rx_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
